sliding_window_source: RTL and testbench

SLIDING_WINDOW_SOURCE -- requirements
Module: sliding_window_source

---
 rtl/sliding_window_source.sv | 102 ++++++++++
 tb/tb_sliding_window_source.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_source.sv
// Serial-to-window adapter for the 1-D CNN datapath: collects a sample stream into
// KERNEL_SIZE-long windows stepping by STRIDE, with valid/ready on both sides.
package cnn1d_pkg;
    parameter int unsigned DATA_WIDTH = 16;
endpackage

module sliding_window_source #(
    parameter int unsigned DATA_WIDTH  = cnn1d_pkg::DATA_WIDTH,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned STRIDE      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  window_ready_in,
    input  logic                  window_valid_in,
    input  logic [DATA_WIDTH-1:0] window_data_in,
    input  logic                  window_last_in,
    input  logic                  window_ready_out,
    output logic                  window_valid_out,
    output logic [DATA_WIDTH-1:0] window_data_out [0:KERNEL_SIZE-1]
);

    localparam int unsigned FillW = $clog2(KERNEL_SIZE + 1);
    localparam int unsigned StrW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [FillW-1:0] FillFull = FillW'(KERNEL_SIZE);
    localparam logic [StrW-1:0]  StrLast  = StrW'(STRIDE - 1);

    logic [DATA_WIDTH-1:0] hist_q [0:KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] hist_d [0:KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] win_q  [0:KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] win_d  [0:KERNEL_SIZE-1];
    logic [FillW-1:0]      fill_q, fill_d;
    logic [StrW-1:0]       stride_q, stride_d;
    logic                  valid_q, valid_d;
    logic                  accept;
    logic                  emit;

    // An emission can only occur on an accept, and accepts only happen when the output
    // register is empty or draining, so a pending window is never overwritten.
    assign window_ready_in  = !valid_q || window_ready_out;
    assign accept           = window_valid_in && window_ready_in;
    assign window_valid_out = valid_q;
    assign window_data_out  = win_q;

    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        stride_d = stride_q;
        emit     = 1'b0;
        if (accept) begin
            for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
                hist_d[i] = hist_q[i+1];
            end
            hist_d[KERNEL_SIZE-1] = window_data_in;
            if (fill_q == FillFull) begin
                if (stride_q == StrLast) begin
                    emit     = 1'b1;
                    stride_d = '0;
                end else begin
                    stride_d = stride_q + 1'b1;
                end
            end else begin
                fill_d   = fill_q + 1'b1;
                emit     = (fill_q == FillFull - 1'b1);
                stride_d = '0;
            end
            // Emission above is evaluated first; the sequence then restarts from empty.
            if (window_last_in) begin
                fill_d   = '0;
                stride_d = '0;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        win_d   = win_q;
        if (emit) begin
            valid_d = 1'b1;
            win_d   = hist_d;
        end else if (valid_q && window_ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q   <= '{default: '0};
            win_q    <= '{default: '0};
            fill_q   <= '0;
            stride_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            win_q    <= win_d;
            fill_q   <= fill_d;
            stride_q <= stride_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_sliding_window_source.sv
// Bench for sliding_window_source: two instances (STRIDE 1 and 2) share one stimulus stream
// and are compared each cycle against a sequence-history reference model.
module tb_sliding_window_source;

    localparam int unsigned W    = cnn1d_pkg::DATA_WIDTH;
    localparam int unsigned K    = 3;
    localparam int unsigned MemD = 1024;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in, last_in, ready_out;
    logic [W-1:0] data_in;
    logic         rdy_a, rdy_b, vld_a, vld_b;
    logic [W-1:0] wdo_a [0:K-1];
    logic [W-1:0] wdo_b [0:K-1];

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance record of the samples accepted in the current sequence.
    logic [W-1:0] seq_mem [2][MemD];
    int           seq_len [2];
    logic         exp_vld [2];
    logic [W-1:0] exp_win [2][K];

    always #5 clk = ~clk;

    sliding_window_source #(.DATA_WIDTH(W), .KERNEL_SIZE(K), .STRIDE(1)) dut_a (
        .clk              (clk),
        .rst              (rst_n),
        .window_ready_in  (rdy_a),
        .window_valid_in  (valid_in),
        .window_data_in   (data_in),
        .window_last_in   (last_in),
        .window_ready_out (ready_out),
        .window_valid_out (vld_a),
        .window_data_out  (wdo_a)
    );

    sliding_window_source #(.DATA_WIDTH(W), .KERNEL_SIZE(K), .STRIDE(2)) dut_b (
        .clk              (clk),
        .rst              (rst_n),
        .window_ready_in  (rdy_b),
        .window_valid_in  (valid_in),
        .window_data_in   (data_in),
        .window_last_in   (last_in),
        .window_ready_out (ready_out),
        .window_valid_out (vld_b),
        .window_data_out  (wdo_b)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int stride_of(input int idx);
        return (idx == 0) ? 1 : 2;
    endfunction

    task automatic model_reset();
        for (int idx = 0; idx < 2; idx++) begin
            seq_len[idx] = 0;
            exp_vld[idx] = 1'b0;
            for (int j = 0; j < K; j++) exp_win[idx][j] = '0;
        end
    endtask

    // Applies the window rules for one rising edge, using the inputs present at that edge.
    task automatic model_clock();
        for (int idx = 0; idx < 2; idx++) begin
            logic rdy;
            logic emit;
            int   n;
            rdy  = !exp_vld[idx] || ready_out;
            emit = 1'b0;
            if (valid_in && rdy) begin
                seq_mem[idx][seq_len[idx] % MemD] = data_in;
                seq_len[idx]++;
                n = seq_len[idx];
                if (n >= K && ((n - K) % stride_of(idx)) == 0) begin
                    emit = 1'b1;
                    for (int j = 0; j < K; j++) exp_win[idx][j] = seq_mem[idx][(n - K + j) % MemD];
                end
                if (last_in) seq_len[idx] = 0;
            end
            if (emit) exp_vld[idx] = 1'b1;
            else if (exp_vld[idx] && ready_out) exp_vld[idx] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int idx = 0; idx < 2; idx++) begin
            logic exp_rdy;
            exp_rdy = !exp_vld[idx] || ready_out;
            check_eq($sformatf("ready_in[%0d]", idx), W'(idx == 0 ? rdy_a : rdy_b), W'(exp_rdy));
            check_eq($sformatf("valid_out[%0d]", idx), W'(idx == 0 ? vld_a : vld_b),
                     W'(exp_vld[idx]));
            for (int j = 0; j < K; j++) begin
                check_eq($sformatf("data_out[%0d][%0d]", idx, j),
                         idx == 0 ? wdo_a[j] : wdo_b[j], exp_win[idx][j]);
            end
        end
    endtask

    // Called at posedge+1; drives one cycle of inputs, checks, then advances past the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic ro);
        valid_in  = v;
        data_in   = d;
        last_in   = l;
        ready_out = ro;
        #1;
        check_outputs();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic feed(input logic [W-1:0] d, input logic l);
        cycle(1'b1, d, l, 1'b1);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        valid_in = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_win(input string tag, input int idx, input logic v,
                             input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] w2);
        check_eq({tag, "_valid"}, W'(idx == 0 ? vld_a : vld_b), W'(v));
        if (v) begin
            check_eq({tag, "_w0"}, idx == 0 ? wdo_a[0] : wdo_b[0], w0);
            check_eq({tag, "_w1"}, idx == 0 ? wdo_a[1] : wdo_b[1], w1);
            check_eq({tag, "_w2"}, idx == 0 ? wdo_a[2] : wdo_b[2], w2);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        last_in   = 1'b0;
        ready_out = 1'b0;
        data_in   = '0;
        model_reset();
        #2;
        check_outputs();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous stream, stride 1
        feed(W'(5), 1'b0);
        feed(W'(10), 1'b0);
        check_win("k3s1_none", 0, 1'b0, '0, '0, '0);
        feed(W'(15), 1'b0);
        check_win("k3s1_first", 0, 1'b1, W'(5), W'(10), W'(15));
        feed(W'(20), 1'b0);
        check_win("k3s1_second", 0, 1'b1, W'(10), W'(15), W'(20));
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Stride 2 on instance b
        async_reset();
        for (int i = 1; i <= 7; i++) begin
            feed(W'(i), 1'b0);
            if (i == 3) check_win("k3s2_w1", 1, 1'b1, W'(1), W'(2), W'(3));
            if (i == 4) check_win("k3s2_gap", 1, 1'b0, '0, '0, '0);
            if (i == 5) check_win("k3s2_w2", 1, 1'b1, W'(3), W'(4), W'(5));
            if (i == 7) check_win("k3s2_w3", 1, 1'b1, W'(5), W'(6), W'(7));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Backpressure holds the pending window and blocks the next sample
        async_reset();
        feed(W'(5), 1'b0);
        feed(W'(10), 1'b0);
        feed(W'(15), 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, W'(20), 1'b0, 1'b0);
            check_win("bp_hold", 0, 1'b1, W'(5), W'(10), W'(15));
            check_eq("bp_ready_in", W'(rdy_a), W'(0));
        end
        cycle(1'b1, W'(20), 1'b0, 1'b1);
        check_win("bp_release", 0, 1'b1, W'(10), W'(15), W'(20));
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Last marks a partial sequence that must be discarded
        async_reset();
        feed(W'(1), 1'b0);
        feed(W'(2), 1'b1);
        feed(W'(3), 1'b0);
        feed(W'(4), 1'b0);
        check_win("last_no_span", 0, 1'b0, '0, '0, '0);
        feed(W'(5), 1'b0);
        check_win("last_first", 0, 1'b1, W'(3), W'(4), W'(5));
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Reset after two samples
        async_reset();
        feed(W'(1), 1'b0);
        feed(W'(2), 1'b0);
        async_reset();
        check_eq("rst_valid_a", W'(vld_a), W'(0));
        feed(W'(7), 1'b0);
        feed(W'(8), 1'b0);
        check_win("rst_partial", 0, 1'b0, '0, '0, '0);
        feed(W'(9), 1'b0);
        check_win("rst_window", 0, 1'b1, W'(7), W'(8), W'(9));

        // Signed passthrough
        async_reset();
        feed(W'(-5), 1'b0);
        feed(W'(0), 1'b0);
        feed(W'(5), 1'b0);
        check_win("signed", 0, 1'b1, W'(-5), W'(0), W'(5));

        // Randomised traffic; data/last toggle freely while not accepted
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 2) != 0));
            end
        end
        cycle(1'b0, '0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
